// File: rtl/dp_controller.sv
// dp_controller: fetch/decode/execute sequencer for the 8-bit accumulator
// datapath. Drives every datapath control line from the state register.
// JZ, JPOS and INPUT also use the current inputs, Mealy style.
//
// Ports:
//   Clock    in   system clock (divided clock from the top level)
//   Reset    in   synchronous active-high reset
//   IR[2:0]  in   opcode from the instruction register
//   Aeq0     in   accumulator == 0
//   Apos     in   accumulator > 0 (signed)
//   Enter    in   user confirm for INPUT, synchronous to Clock
//   IRload   out  load IR from memory
//   JMPmux   out  PC source: 1 = IR address field, 0 = PC+1
//   PCload   out  load PC
//   Meminst  out  memory address source: 1 = IR address field, 0 = PC
//   MemWr    out  memory write strobe
//   Asel     out  accumulator source: 00 add/sub, 01 Input, 10 memory
//   Aload    out  load accumulator
//   Sub      out  1 = subtract, 0 = add
//   Halt     out  high while in HALT
//   State    out  current state code, for LEDs and checkers
//
// Enter handshake: INPUT waits until the enter condition is seen.
// With ENTER_EDGE=1, the condition is a rising edge of Enter. With
// ENTER_EDGE=0, the condition is Enter at level high. The accumulator
// loads in the cycle the condition holds, and the FSM leaves INPUT on that
// same clock edge.
module dp_controller #(
  parameter bit ENTER_EDGE = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [2:0] IR,
  input  logic       Aeq0,
  input  logic       Apos,
  input  logic       Enter,
  output logic       IRload,
  output logic       JMPmux,
  output logic       PCload,
  output logic       Meminst,
  output logic       MemWr,
  output logic [1:0] Asel,
  output logic       Aload,
  output logic       Sub,
  output logic       Halt,
  output logic [3:0] State
);

  localparam logic [3:0] S_START  = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_LOAD   = 4'd3;
  localparam logic [3:0] S_STORE  = 4'd4;
  localparam logic [3:0] S_ADD    = 4'd5;
  localparam logic [3:0] S_SUB    = 4'd6;
  localparam logic [3:0] S_INPUT  = 4'd7;
  localparam logic [3:0] S_JZ     = 4'd8;
  localparam logic [3:0] S_JPOS   = 4'd9;
  localparam logic [3:0] S_HALT   = 4'd10;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       enter_q;
  logic       enter_ok;

  // enter_q resets to 1. An Enter that is held high through reset
  // therefore does not count as a rising edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_START;
      enter_q <= 1'b1;
    end else begin
      state_q <= state_d;
      enter_q <= Enter;
    end
  end

  assign enter_ok = ENTER_EDGE ? (Enter & ~enter_q) : Enter;
  assign State    = state_q;

  always_comb begin
    state_d = S_START;
    unique case (state_q)
      S_START:  state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (IR)
          3'b000: state_d = S_LOAD;
          3'b001: state_d = S_STORE;
          3'b010: state_d = S_ADD;
          3'b011: state_d = S_SUB;
          3'b100: state_d = S_INPUT;
          3'b101: state_d = S_JZ;
          3'b110: state_d = S_JPOS;
          default: state_d = S_HALT;
        endcase
      end
      S_INPUT:  state_d = enter_ok ? S_START : S_INPUT;
      S_HALT:   state_d = S_HALT;
      // Execute states, and the illegal codes 11-15, all go to START.
      default:  state_d = S_START;
    endcase
  end

  always_comb begin
    IRload  = 1'b0;
    JMPmux  = 1'b0;
    PCload  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    Asel    = 2'b00;
    Aload   = 1'b0;
    Sub     = 1'b0;
    Halt    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        IRload = 1'b1;
        PCload = 1'b1;
      end
      S_DECODE: Meminst = 1'b1;
      S_LOAD: begin
        Meminst = 1'b1;
        Asel    = 2'b10;
        Aload   = 1'b1;
      end
      S_STORE: begin
        Meminst = 1'b1;
        MemWr   = 1'b1;
      end
      S_ADD: begin
        Meminst = 1'b1;
        Aload   = 1'b1;
      end
      S_SUB: begin
        Meminst = 1'b1;
        Aload   = 1'b1;
        Sub     = 1'b1;
      end
      S_INPUT: begin
        Asel  = 2'b01;
        Aload = enter_ok;
      end
      // The flags are stable here because A is not loaded in FETCH or DECODE.
      S_JZ: begin
        JMPmux = 1'b1;
        PCload = Aeq0;
      end
      S_JPOS: begin
        JMPmux = 1'b1;
        PCload = Apos;
      end
      S_HALT:  Halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dp_controller.sv
// Testbench for dp_controller. Two instances share every input: dut_e uses
// ENTER_EDGE=1 and dut_l uses ENTER_EDGE=0. The driver pushes the expected
// output vector for each cycle. A monitor pops and compares it on the
// falling clock edge.
// Vector layout: {State[3:0], IRload, JMPmux, PCload, Meminst, MemWr,
//                 Asel[1:0], Aload, Sub, Halt}
module tb_dp_controller;

  localparam logic [13:0] V_START   = {4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] V_FETCH   = {4'd1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] V_DECODE  = {4'd2,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] V_LOAD    = {4'd3,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0};
  localparam logic [13:0] V_STORE   = {4'd4,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] V_ADD     = {4'd5,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
  localparam logic [13:0] V_SUB     = {4'd6,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0};
  localparam logic [13:0] V_IN_WAIT = {4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] V_IN_TAKE = {4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0};
  localparam logic [13:0] V_JZ_T    = {4'd8,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] V_JZ_N    = {4'd8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] V_JP_T    = {4'd9,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] V_JP_N    = {4'd9,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] V_HALT    = {4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};

  logic       Clock;
  logic       Reset;
  logic [2:0] IR;
  logic       Aeq0;
  logic       Apos;
  logic       Enter;

  logic       irload_e, jmpmux_e, pcload_e, meminst_e, memwr_e, aload_e, sub_e, halt_e;
  logic [1:0] asel_e;
  logic [3:0] state_e;
  logic       irload_l, jmpmux_l, pcload_l, meminst_l, memwr_l, aload_l, sub_l, halt_l;
  logic [1:0] asel_l;
  logic [3:0] state_l;

  logic [13:0] exp_e_q[$];
  logic [13:0] exp_l_q[$];
  string       tag_e_q[$];
  string       tag_l_q[$];
  int          checks;
  int          errors;

  dp_controller #(.ENTER_EDGE(1'b1)) dut_e (
    .Clock(Clock), .Reset(Reset), .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .Enter(Enter),
    .IRload(irload_e), .JMPmux(jmpmux_e), .PCload(pcload_e), .Meminst(meminst_e),
    .MemWr(memwr_e), .Asel(asel_e), .Aload(aload_e), .Sub(sub_e), .Halt(halt_e),
    .State(state_e)
  );

  dp_controller #(.ENTER_EDGE(1'b0)) dut_l (
    .Clock(Clock), .Reset(Reset), .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .Enter(Enter),
    .IRload(irload_l), .JMPmux(jmpmux_l), .PCload(pcload_l), .Meminst(meminst_l),
    .MemWr(memwr_l), .Asel(asel_l), .Aload(aload_l), .Sub(sub_l), .Halt(halt_l),
    .State(state_l)
  );

  // Clock and reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Monitor / scoreboard
  always @(negedge Clock) begin
    logic [13:0] act;
    logic [13:0] exp_v;
    string       tag;
    if (exp_e_q.size() > 0) begin
      exp_v = exp_e_q.pop_front();
      tag   = tag_e_q.pop_front();
      act   = {state_e, irload_e, jmpmux_e, pcload_e, meminst_e, memwr_e, asel_e, aload_e, sub_e, halt_e};
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL %s (edge dut): got=%b expected=%b", tag, act, exp_v);
      end
    end
    if (exp_l_q.size() > 0) begin
      exp_v = exp_l_q.pop_front();
      tag   = tag_l_q.pop_front();
      act   = {state_l, irload_l, jmpmux_l, pcload_l, meminst_l, memwr_l, asel_l, aload_l, sub_l, halt_l};
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL %s (level dut): got=%b expected=%b", tag, act, exp_v);
      end
    end
  end

  // Driver tasks
  task automatic cyc(input logic [13:0] ve, input bit chk_l, input logic [13:0] vl,
                     input string tag);
    exp_e_q.push_back(ve);
    tag_e_q.push_back(tag);
    if (chk_l) begin
      exp_l_q.push_back(vl);
      tag_l_q.push_back(tag);
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
  endtask

  task automatic run_instr(input logic [2:0] ir, input logic [13:0] ex, input string tag);
    IR = ir;
    cyc(V_START,  1'b1, V_START,  {tag, "_start"});
    cyc(V_FETCH,  1'b1, V_FETCH,  {tag, "_fetch"});
    cyc(V_DECODE, 1'b1, V_DECODE, {tag, "_decode"});
    cyc(ex,       1'b1, ex,       {tag, "_exec"});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset  = 1'b1;
    IR     = 3'b000;
    Aeq0   = 1'b0;
    Apos   = 1'b0;
    Enter  = 1'b0;
    @(posedge Clock);
    #1;
    do_reset();

    // Basic instructions, 4 cycles each, back to back
    run_instr(3'b000, V_LOAD,  "load");
    run_instr(3'b001, V_STORE, "store");
    run_instr(3'b010, V_ADD,   "add");
    run_instr(3'b011, V_SUB,   "sub");
    Aeq0 = 1'b1; run_instr(3'b101, V_JZ_T, "jz_taken");
    Aeq0 = 1'b0; run_instr(3'b101, V_JZ_N, "jz_not");
    Apos = 1'b1; run_instr(3'b110, V_JP_T, "jpos_taken");
    Apos = 1'b0; run_instr(3'b110, V_JP_N, "jpos_not");
    cyc(V_START, 1'b1, V_START, "after_jpos");

    // INPUT: Enter held through reset. Edge mode waits, level mode takes at once.
    Enter = 1'b1;
    IR    = 3'b100;
    do_reset();
    cyc(V_START,   1'b1, V_START,   "in_start");
    cyc(V_FETCH,   1'b1, V_FETCH,   "in_fetch");
    cyc(V_DECODE,  1'b1, V_DECODE,  "in_decode");
    cyc(V_IN_WAIT, 1'b1, V_IN_TAKE, "in_held_1");
    cyc(V_IN_WAIT, 1'b1, V_START,   "in_held_2");
    cyc(V_IN_WAIT, 1'b1, V_FETCH,   "in_held_3");
    Enter = 1'b0;
    cyc(V_IN_WAIT, 1'b1, V_DECODE,  "in_low");
    Enter = 1'b1;
    cyc(V_IN_TAKE, 1'b1, V_IN_TAKE, "in_edge");
    cyc(V_START,   1'b1, V_START,   "in_done");

    // HALT holds regardless of IR and Enter until Reset
    Enter = 1'b0;
    do_reset();
    run_instr(3'b111, V_HALT, "halt");
    for (int i = 0; i < 20; i++) begin
      IR    = 3'($urandom_range(0, 7));
      Enter = 1'($urandom_range(0, 1));
      cyc(V_HALT, 1'b1, V_HALT, "halt_hold");
    end
    do_reset();
    cyc(V_START, 1'b1, V_START, "halt_reset");

    // Reset while waiting in INPUT, with Enter rising in that same cycle
    Enter = 1'b0;
    IR    = 3'b100;
    cyc(V_FETCH,   1'b1, V_FETCH,   "rin_fetch");
    cyc(V_DECODE,  1'b1, V_DECODE,  "rin_decode");
    cyc(V_IN_WAIT, 1'b1, V_IN_WAIT, "rin_wait");
    Reset = 1'b1;
    Enter = 1'b1;
    cyc(V_IN_TAKE, 1'b1, V_IN_TAKE, "rin_resetcyc");
    Reset = 1'b0;
    cyc(V_START,   1'b1, V_START,   "rin_after");

    // Reset during STORE; MemWr must drop
    IR = 3'b001;
    cyc(V_FETCH,  1'b1, V_FETCH,  "rst_fetch");
    cyc(V_DECODE, 1'b1, V_DECODE, "rst_decode");
    Reset = 1'b1;
    cyc(V_STORE,  1'b1, V_STORE,  "rst_store");
    Reset = 1'b0;
    cyc(V_START,  1'b1, V_START,  "rst_after");
    cyc(V_FETCH,  1'b1, V_FETCH,  "rst_refetch");

    // Every expected vector must have been consumed by the monitor.
    @(negedge Clock);
    checks++;
    if (exp_e_q.size() != 0 || exp_l_q.size() != 0) begin
      errors++;
      $display("FAIL drain: left=%0d/%0d expected=0/0", exp_e_q.size(), exp_l_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dp_controller.md
Name: dp_controller

Overview:
- Moore/Mealy FSM that sequences the 8-bit accumulator datapath through fetch, decode and execute.
- Drives every datapath control line: IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub.
- Reads back the opcode IR[2:0] and the status flags Aeq0/Apos.
- Sits between the board top level and the datapath, replacing the manual switch drive of the control lines.

Parameters:
- ENTER_EDGE, 1, 1 = INPUT waits for a rising edge of Enter; 0 = INPUT waits for Enter at level high.

Ports:
- Clock  in  1  system clock (divided clock from the top level)
- Reset  in  1  synchronous, active-high reset; one clock; state and all outputs return to reset values at the next rising Clock edge
- IR  in  3  opcode from the datapath instruction register
- Aeq0  in  1  accumulator == 0
- Apos  in  1  accumulator > 0 (signed)
- Enter  in  1  user confirm for INPUT, synchronous to Clock
- IRload  out  1  load IR from memory
- JMPmux  out  1  PC source: 1 = IR address field, 0 = PC+1
- PCload  out  1  load PC
- Meminst  out  1  memory address source: 1 = IR address field, 0 = PC
- MemWr  out  1  memory write strobe
- Asel  out  2  accumulator source: 00 = add/sub result, 01 = Input, 10 = memory, 11 = unused
- Aload  out  1  load accumulator
- Sub  out  1  1 = subtract, 0 = add
- Halt  out  1  high while in HALT
- State  out  4  current state code, for LEDs

Behaviour:
- State codes:
  - START=0, FETCH=1, DECODE=2, LOAD=3, STORE=4, ADD=5, SUB=6, INPUT=7, JZ=8, JPOS=9, HALT=10.
  - Codes 11-15 are illegal and go to START on the next edge.
- Reset:
  - State=START.
  - All control outputs are 0 in START; Halt=0; State=0.
  - Reset has priority over every transition, including mid-INPUT wait and HALT.
- Outputs are decoded from the state register. All unlisted outputs are 0 in each state.
  - START: none. Next state FETCH.
  - FETCH: IRload=1, PCload=1, JMPmux=0, Meminst=0. Next state DECODE.
  - DECODE: Meminst=1. Next state by IR:
    - 000 LOAD
    - 001 STORE
    - 010 ADD
    - 011 SUB
    - 100 INPUT
    - 101 JZ
    - 110 JPOS
    - 111 HALT
  - LOAD: Meminst=1, Asel=10, Aload=1. Next state START.
  - STORE: Meminst=1, MemWr=1. Next state START.
  - ADD: Meminst=1, Asel=00, Aload=1, Sub=0. Next state START.
  - SUB: Meminst=1, Asel=00, Aload=1, Sub=1. Next state START.
  - INPUT: Asel=01.
    - Aload=1 only in the cycle the enter condition is true; the FSM leaves to START on that edge.
    - Otherwise it stays in INPUT with Aload=0.
    - Enter condition with ENTER_EDGE=1: Enter=1 and Enter registered previous cycle=0. The edge register resets to 1, so an Enter held through reset is not taken as an edge.
  - JZ: JMPmux=1 and PCload=Aeq0 (Mealy on Aeq0). Next state START.
  - JPOS: JMPmux=1 and PCload=Apos. Next state START.
  - HALT: Halt=1, all other controls 0. Stays in HALT until Reset.
- Latency:
  - Every non-INPUT instruction takes 4 cycles: START, FETCH, DECODE, execute.
  - INPUT takes 4 cycles plus the wait for the enter condition.
- MemWr is high for exactly one cycle per STORE.
- PCload is never high in DECODE, so there is no double increment.
- Aeq0 and Apos are sampled combinationally in JZ/JPOS. The datapath holds them stable because A is not loaded in FETCH or DECODE.

Test Plan:
- Reset, then IR=000 held.
  - Cycles: START → FETCH (IRload=PCload=1) → DECODE (Meminst=1) → LOAD (Asel=10, Aload=1, Meminst=1) → START.
  - State trace 0,1,2,3,0.
- Opcodes 001, 010, 011:
  - STORE: MemWr=1 for exactly one cycle.
  - ADD: Sub=0, Aload=1, Asel=00.
  - SUB: Sub=1, Aload=1, Asel=00.
  - Each returns to START after 4 cycles.
- JZ (IR=101):
  - Aeq0=1 → JMPmux=1, PCload=1.
  - Aeq0=0 → JMPmux=1, PCload=0.
  - JPOS (IR=110) tested the same way with Apos.
- INPUT (IR=100), ENTER_EDGE=1:
  - Enter held 1 through reset, then kept 1 → FSM stays in INPUT, Aload=0.
  - Enter dropped to 0 then raised to 1 → Aload=1 for one cycle, then START.
  - Repeat with ENTER_EDGE=0: Enter=1 on entry → Aload=1 immediately.
- HALT (IR=111):
  - Halt=1 and State=10 hold for 20 cycles regardless of IR/Enter.
  - Reset pulse → State=0, Halt=0 on the next edge.
- Reset mid-instruction:
  - Assert Reset during INPUT wait and during STORE.
  - Next edge: State=0 and all controls 0.
  - MemWr must not stay high after reset.
